// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, the
// general-call address and the ACK/NACK bus levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } i2c_slave_state_t;

    localparam logic [6:0] I2C_GENERAL_CALL_ADDR = 7'h00;
    localparam logic       I2C_ACK               = 1'b0;
    localparam logic       I2C_NACK              = 1'b1;

endpackage

// File: rtl/i2c_bus_sync_detect.sv
// SCL/SDA synchronizers plus SCL edge strobes and START/STOP detection.
// All strobes are combinational from the synchronized copies, one cycle wide.
module i2c_bus_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    logic                   scl_s;
    logic                   sda_s;

    // Synchronizers reset to 1 so an idle (pulled-up) bus shows no edge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic scl_d;
            logic sda_d;
            if (gi == 0) begin : g_pin
                assign scl_d = scl_i;
                assign sda_d = sda_i;
            end else begin : g_chain
                assign scl_d = scl_sync_reg[gi-1];
                assign sda_d = sda_sync_reg[gi-1];
            end
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    scl_sync_reg[gi] <= 1'b1;
                    sda_sync_reg[gi] <= 1'b1;
                end else begin
                    scl_sync_reg[gi] <= scl_d;
                    sda_sync_reg[gi] <= sda_d;
                end
            end
        end
    endgenerate

    assign scl_s = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s = sda_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_reg;
    assign scl_fall_o = ~scl_s & scl_prev_reg;
    // STOP wins if both ever decode together.
    assign stop_o     = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
    assign start_o    = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s & ~stop_o;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a byte memory: first written byte sets the pointer, later
// bytes are stored; reads stream from the pointer. Option: I2C_SLAVE_GENERAL_CALL_EN.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         MEM_DEPTH   = 32,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       busy_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       wr_valid_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o
);

    localparam int PTR_W = $clog2(MEM_DEPTH);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    i2c_slave_state_t state_reg, state_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       tx_reg, tx_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic             ptr_loaded_reg, ptr_loaded_next;
    logic             gc_reg, gc_next;
    logic             sda_oe_reg, sda_oe_next;
    logic             busy_reg, busy_next;
    logic             start_reg, start_next;
    logic             stop_reg, stop_next;
    logic             wr_valid_reg, wr_valid_next;
    logic [7:0]       wr_addr_reg, wr_addr_next;
    logic [7:0]       wr_data_reg, wr_data_next;
    logic [7:0]       rd_data_reg;
    logic [7:0]       tx_shift;
    logic [7:0]       rx_byte;
    logic             mem_we;
    logic             gc_hit;

    logic [7:0] mem [MEM_DEPTH];

    assign rx_byte  = {shift_reg[6:0], sda_s};
    assign tx_shift = {tx_reg[6:0], 1'b0};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign gc_hit = (rx_byte[7:1] == I2C_GENERAL_CALL_ADDR) && !rx_byte[0];
`else
    assign gc_hit = 1'b0;
`endif

    // Read data is prefetched continuously; the pointer settles long before
    // the SCL falling edge that launches the next byte.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[ptr_reg] <= rx_byte;
        end
        rd_data_reg <= mem[ptr_reg];
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        tx_next         = tx_reg;
        ptr_next        = ptr_reg;
        ptr_loaded_next = ptr_loaded_reg;
        gc_next         = gc_reg;
        sda_oe_next     = sda_oe_reg;
        busy_next       = busy_reg;
        start_next      = 1'b0;
        stop_next       = 1'b0;
        wr_valid_next   = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        mem_we          = 1'b0;

        if (stop_det) begin
            state_next  = IDLE;
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
            stop_next   = 1'b1;
        end else if (start_det) begin
            state_next      = ADDR;
            bit_cnt_next    = 4'd0;
            sda_oe_next     = 1'b0;
            busy_next       = 1'b1;
            start_next      = 1'b1;
            ptr_loaded_next = 1'b0;
            gc_next         = 1'b0;
        end else begin
            case (state_reg)
                ADDR: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_next = ADDR_ACK;
                            end else if (gc_hit) begin
                                state_next = ADDR_ACK;
                                gc_next    = 1'b1;
                            end else begin
                                state_next = WAIT_STOP;
                            end
                        end
                    end
                end
                // bit_cnt 0: ACK not yet driven; 1: ACK clock in progress.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 4'd0) begin
                            sda_oe_next  = ~I2C_ACK;
                            bit_cnt_next = 4'd1;
                        end else begin
                            bit_cnt_next = 4'd0;
                            if (shift_reg[0]) begin
                                state_next  = RD_BYTE;
                                tx_next     = rd_data_reg;
                                sda_oe_next = ~rd_data_reg[7];
                                ptr_next    = ptr_reg + PTR_W'(1);
                            end else begin
                                state_next  = WR_BYTE;
                                sda_oe_next = 1'b0;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            state_next   = WR_ACK;
                            if (gc_reg) begin
                                ptr_next = ptr_reg;
                            end else if (!ptr_loaded_reg) begin
                                ptr_next        = rx_byte[PTR_W-1:0];
                                ptr_loaded_next = 1'b1;
                            end else begin
                                mem_we        = 1'b1;
                                wr_valid_next = 1'b1;
                                wr_addr_next  = 8'(ptr_reg);
                                wr_data_next  = rx_byte;
                                ptr_next      = ptr_reg + PTR_W'(1);
                            end
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 4'd0) begin
                            sda_oe_next  = ~I2C_ACK;
                            bit_cnt_next = 4'd1;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 4'd0;
                            state_next   = WR_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 4'd0;
                            state_next   = RD_ACK;
                        end else begin
                            tx_next     = tx_shift;
                            sda_oe_next = ~tx_shift[7];
                        end
                    end
                end
                // bit_cnt becomes 1 once the master's ACK has been seen.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            bit_cnt_next = 4'd1;
                        end else begin
                            state_next = WAIT_STOP;
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd1) begin
                        bit_cnt_next = 4'd0;
                        state_next   = RD_BYTE;
                        tx_next      = rd_data_reg;
                        sda_oe_next  = ~rd_data_reg[7];
                        ptr_next     = ptr_reg + PTR_W'(1);
                    end
                end
                default: begin
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'd0;
            tx_reg         <= 8'd0;
            ptr_reg        <= '0;
            ptr_loaded_reg <= 1'b0;
            gc_reg         <= 1'b0;
            sda_oe_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            start_reg      <= 1'b0;
            stop_reg       <= 1'b0;
            wr_valid_reg   <= 1'b0;
            wr_addr_reg    <= 8'd0;
            wr_data_reg    <= 8'd0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            tx_reg         <= tx_next;
            ptr_reg        <= ptr_next;
            ptr_loaded_reg <= ptr_loaded_next;
            gc_reg         <= gc_next;
            sda_oe_reg     <= sda_oe_next;
            busy_reg       <= busy_next;
            start_reg      <= start_next;
            stop_reg       <= stop_next;
            wr_valid_reg   <= wr_valid_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
        end
    end

    assign sda_oe_o   = sda_oe_reg;
    assign busy_o     = busy_reg;
    assign start_o    = start_reg;
    assign stop_o     = stop_reg;
    assign wr_valid_o = wr_valid_reg;
    assign wr_addr_o  = wr_addr_reg;
    assign wr_data_o  = wr_data_reg;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Scoreboard bench for i2c_slave_responder: a bit-banged I2C master pushes
// expected ACK bits, read bytes and memory writes; monitors pop and compare.
module tb_i2c_slave_responder;

    localparam int         Q  = 10;
    localparam logic [7:0] AW = 8'h44;
    localparam logic [7:0] AR = 8'h45;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    logic       sda_oe, busy, start_p, stop_p, wr_valid;
    logic [7:0] wr_addr, wr_data;
    wire        sda = sda_m & ~sda_oe;

    i2c_slave_responder #(
        .SLAVE_ADDR  (7'h22),
        .MEM_DEPTH   (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .scl_i      (scl_m),
        .sda_i      (sda),
        .sda_oe_o   (sda_oe),
        .busy_o     (busy),
        .start_o    (start_p),
        .stop_o     (stop_p),
        .wr_valid_o (wr_valid),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rsp[$];
    string      exp_rsp_name[$];
    logic [7:0] rsp_data;
    event       rsp_ev;

    int   n_pass = 0;
    int   n_total = 0;
    int   start_cnt = 0;
    int   stop_cnt = 0;
    int   oe_viol = 0;
    logic watch_quiet = 1'b0;
    int   s0, p0;
    wr_t  w_pop;
    string nm_pop;
    logic [7:0] v_pop;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        r = sda;      wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input string nm, input logic [7:0] d, input logic exp_bit);
        logic r;
        exp_rsp.push_back({7'd0, exp_bit});
        exp_rsp_name.push_back(nm);
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, r);
        rsp_data = {7'd0, r};
        -> rsp_ev;
        $display("tx  %-16s byte=%02h ack_bit=%0b", nm, d, r);
    endtask

    task automatic recv_byte(input string nm, input logic [7:0] exp, input logic ack);
        logic r;
        logic [7:0] b;
        b = 8'd0;
        exp_rsp.push_back(exp);
        exp_rsp_name.push_back(nm);
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, r);
            b = {b[6:0], r};
        end
        rsp_data = b;
        -> rsp_ev;
        bus_bit(ack, r);
        $display("rx  %-16s byte=%02h master_ack=%0b", nm, b, ack);
    endtask

    task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    // Response monitor: ACK bits and read bytes seen by the master.
    initial begin
        forever begin
            @(rsp_ev);
            if (exp_rsp.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: got %02h, want none", rsp_data);
            end else begin
                nm_pop = exp_rsp_name.pop_front();
                v_pop  = exp_rsp.pop_front();
                check(nm_pop, {8'd0, rsp_data}, {8'd0, v_pop});
            end
        end
    end

    // Output monitor: memory-write strobes and bus event pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (start_p) start_cnt++;
            if (stop_p) stop_cnt++;
            if (watch_quiet && sda_oe) oe_viol++;
            if (wr_valid) begin
                $display("wr  addr=%0d data=%02h", wr_addr, wr_data);
                if (exp_wr.size() == 0) begin
                    n_total++;
                    $display("FAIL wr_unexpected: got addr %0d data %02h, want none", wr_addr, wr_data);
                end else begin
                    w_pop = exp_wr.pop_front();
                    check("wr_addr", {8'd0, wr_addr}, {8'd0, w_pop.a});
                    check("wr_data", {8'd0, wr_data}, {8'd0, w_pop.d});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(5);
        check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_start", {15'd0, start_p}, 16'd0);
        check("rst_stop", {15'd0, stop_p}, 16'd0);
        check("rst_wr_valid", {15'd0, wr_valid}, 16'd0);
        check("rst_wr_bus", {wr_addr, wr_data}, 16'd0);
        rst_n = 1'b1;
        wait_clk(Q);

        // Pointer 5, then two stored bytes.
        p0 = stop_cnt;
        exp_write(8'd5, 8'hA5);
        exp_write(8'd6, 8'h5A);
        bus_start();
        check("busy_after_start", {15'd0, busy}, 16'd1);
        send_byte("t1_addr", AW, 1'b0);
        send_byte("t1_ptr", 8'h05, 1'b0);
        send_byte("t1_d0", 8'hA5, 1'b0);
        send_byte("t1_d1", 8'h5A, 1'b0);
        bus_stop();
        wait_clk(Q);
        check("t1_busy_idle", {15'd0, busy}, 16'd0);
        check("t1_stop_pulses", 16'(stop_cnt - p0), 16'd1);

        // Set pointer, repeated START, read two bytes.
        s0 = start_cnt;
        bus_start();
        send_byte("t2_addr_w", AW, 1'b0);
        send_byte("t2_ptr", 8'h05, 1'b0);
        bus_start();
        send_byte("t2_addr_r", AR, 1'b0);
        recv_byte("t2_rd0", 8'hA5, 1'b0);
        recv_byte("t2_rd1", 8'h5A, 1'b1);
        wait_clk(4);
        check("t2_sda_released", {15'd0, sda_oe}, 16'd0);
        bus_stop();
        wait_clk(Q);
        check("t2_start_pulses", 16'(start_cnt - s0), 16'd2);

        // Foreign address: NACK and silence until STOP.
        bus_start();
        send_byte("t3_addr_nack", 8'h46, 1'b1);
        oe_viol = 0;
        watch_quiet = 1'b1;
        send_byte("t3_d0_nack", 8'h00, 1'b1);
        send_byte("t3_d1_nack", 8'h3C, 1'b1);
        watch_quiet = 1'b0;
        check("t3_no_drive", 16'(oe_viol), 16'd0);
        check("t3_busy_held", {15'd0, busy}, 16'd1);
        bus_stop();
        wait_clk(Q);
        check("t3_busy_cleared", {15'd0, busy}, 16'd0);

        // Pointer wrap at the top of memory.
        exp_write(8'd31, 8'h11);
        exp_write(8'd0, 8'h22);
        bus_start();
        send_byte("t4_addr_w", AW, 1'b0);
        send_byte("t4_ptr", 8'h1F, 1'b0);
        send_byte("t4_d0", 8'h11, 1'b0);
        send_byte("t4_d1", 8'h22, 1'b0);
        bus_stop();
        bus_start();
        send_byte("t4_addr_w2", AW, 1'b0);
        send_byte("t4_ptr2", 8'h1F, 1'b0);
        bus_start();
        send_byte("t4_addr_r", AR, 1'b0);
        recv_byte("t4_rd31", 8'h11, 1'b0);
        recv_byte("t4_rd0", 8'h22, 1'b1);
        bus_stop();

        // Reset while the target drives a 0 data bit (mem[6] = 0x5A).
        bus_start();
        send_byte("t5_addr_w", AW, 1'b0);
        send_byte("t5_ptr", 8'h06, 1'b0);
        bus_start();
        send_byte("t5_addr_r", AR, 1'b0);
        check("t5_drive_before_rst", {15'd0, sda_oe}, 16'd1);
        rst_n = 1'b0;
        wait_clk(1);
        check("t5_rst_release", {15'd0, sda_oe}, 16'd0);
        check("t5_rst_busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        exp_write(8'd0, 8'h77);
        bus_start();
        send_byte("t5_post_addr", AW, 1'b0);
        send_byte("t5_post_ptr", 8'h00, 1'b0);
        send_byte("t5_post_d", 8'h77, 1'b0);
        bus_stop();
        bus_start();
        send_byte("t5_rb_addr_w", AW, 1'b0);
        send_byte("t5_rb_ptr", 8'h00, 1'b0);
        bus_start();
        send_byte("t5_rb_addr_r", AR, 1'b0);
        recv_byte("t5_rb_data", 8'h77, 1'b1);
        bus_stop();

        // General call: ACKed and discarded when enabled, NACKed otherwise.
        bus_start();
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        send_byte("t6_gc_addr_ack", 8'h00, 1'b0);
        send_byte("t6_gc_data_ack", 8'h3C, 1'b0);
`else
        send_byte("t6_gc_addr_nack", 8'h00, 1'b1);
`endif
        bus_stop();
        wait_clk(4 * Q);

        check("wr_queue_drained", 16'(exp_wr.size()), 16'd0);
        check("rsp_queue_drained", 16'(exp_rsp.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
